// File: rtl/pri_enc_pkg.sv
// Shared definitions for the priority encoder family: mode selectors and
// the grant FSM state type.
package pri_enc_pkg;

    localparam int MODE_FIXED = 0;
    localparam int MODE_RR    = 1;

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

endpackage

// File: rtl/pri_rotate_enc.sv
// Combinational N-to-W priority encoder with a rotatable priority origin.
// Index `rot` has the lowest priority and `rot-1` the highest, so rot = 0 gives highest-index-wins.
module pri_rotate_enc
    import pri_enc_pkg::*;
#(
    parameter  int N = 8,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] cand,
    input  logic [W-1:0] rot,
    output logic [W-1:0] idx,
    output logic         any
);

    always_comb begin
        int unsigned k;
        idx = '0;
        any = 1'b0;
        k   = 0;
        // Walk the rotated vector from lowest to highest priority; the last hit wins.
        for (int unsigned j = 0; j < N; j++) begin
            k = (j + 32'(rot)) % N;
            if (cand[k[W-1:0]]) begin
                idx = k[W-1:0];
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/priority_irq_ctrl.sv
// Registered N-input priority interrupt controller: edge-detected pending
// latches, writable mask, fixed or round-robin selection, and an irq/id grant held until ack.
module priority_irq_ctrl
    import pri_enc_pkg::*;
#(
    parameter  int N    = 8,
    parameter  int MODE = MODE_FIXED,
    localparam int W    = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         mask_wr,
    input  logic [N-1:0] mask_in,
    input  logic         ack,
    output logic         irq,
    output logic [W-1:0] id,
    output logic [N-1:0] pend,
    output logic [N-1:0] mask
);

    logic [N-1:0] req_q;
    logic [N-1:0] clr;
    logic [N-1:0] cand;
    logic [W-1:0] last;
    logic [W-1:0] rot;
    logic [W-1:0] sel;
    logic         sel_any;
    state_t       state;

    assign cand = pend & ~mask;
    assign rot  = (MODE == MODE_RR) ? last : '0;

    always_comb begin
        clr = '0;
        if (state == GRANT && ack) begin
            clr[id] = 1'b1;
        end
    end

    pri_rotate_enc #(
        .N(N)
    ) u_enc (
        .cand(cand),
        .rot (rot),
        .idx (sel),
        .any (sel_any)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            req_q <= '0;
            pend  <= '0;
            mask  <= '0;
            irq   <= 1'b0;
            id    <= '0;
            last  <= W'(N - 1);
            state <= IDLE;
        end else begin
            req_q <= req;
            // A fresh rise re-sets a bit even while the same bit is being acked.
            pend  <= (pend & ~clr) | (req & ~req_q);
            if (mask_wr) begin
                mask <= mask_in;
            end
            case (state)
                IDLE: begin
                    if (sel_any) begin
                        id    <= sel;
                        irq   <= 1'b1;
                        state <= GRANT;
                    end
                end
                GRANT: begin
                    if (ack) begin
                        irq   <= 1'b0;
                        state <= IDLE;
                        if (MODE == MODE_RR) begin
                            last <= id;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_priority_irq_ctrl.sv
// Scoreboard bench for priority_irq_ctrl: one fixed-priority and one
// round-robin instance, directed stimulus, grants checked by per-instance monitors.
module tb_priority_irq_ctrl;

    localparam int N = 8;
    localparam int W = $clog2(N);

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    logic [N-1:0] f_req = '0, f_mask_in = '0, f_pend, f_mask;
    logic         f_mask_wr = 1'b0, f_ack = 1'b0, f_irq;
    logic [W-1:0] f_id;

    logic [N-1:0] r_req = '0, r_mask_in = '0, r_pend, r_mask;
    logic         r_mask_wr = 1'b0, r_ack = 1'b0, r_irq;
    logic [W-1:0] r_id;

    int vectors     = 0;
    int miscompares = 0;
    int exp_f[$];
    int exp_r[$];

    always #5 clk = ~clk;

    priority_irq_ctrl #(.N(N), .MODE(0)) u_fix (
        .clk(clk), .rst_n(rst_n), .req(f_req), .mask_wr(f_mask_wr),
        .mask_in(f_mask_in), .ack(f_ack), .irq(f_irq), .id(f_id),
        .pend(f_pend), .mask(f_mask)
    );

    priority_irq_ctrl #(.N(N), .MODE(1)) u_rr (
        .clk(clk), .rst_n(rst_n), .req(r_req), .mask_wr(r_mask_wr),
        .mask_in(r_mask_in), .ack(r_ack), .irq(r_irq), .id(r_id),
        .pend(r_pend), .mask(r_mask)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitors: pop the expected id on every new grant, and check id holds while irq stays high.
    logic         f_irq_d = 1'b0, r_irq_d = 1'b0;
    logic [W-1:0] f_id_d = '0, r_id_d = '0;

    always @(negedge clk) begin
        if (f_irq && !f_irq_d) begin
            if (exp_f.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL fix_grant: got unexpected grant id %0d, expected none", f_id);
            end else begin
                check("fix_grant_id", 32'(f_id), 32'(exp_f.pop_front()));
            end
        end else if (f_irq && f_irq_d) begin
            check("fix_id_stable", 32'(f_id), 32'(f_id_d));
        end
        f_irq_d <= f_irq;
        f_id_d  <= f_id;
    end

    always @(negedge clk) begin
        if (r_irq && !r_irq_d) begin
            if (exp_r.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL rr_grant: got unexpected grant id %0d, expected none", r_id);
            end else begin
                check("rr_grant_id", 32'(r_id), 32'(exp_r.pop_front()));
            end
        end else if (r_irq && r_irq_d) begin
            check("rr_id_stable", 32'(r_id), 32'(r_id_d));
        end
        r_irq_d <= r_irq;
        r_id_d  <= r_id;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input bit rr, input logic [N-1:0] bits);
        if (rr) r_req = bits; else f_req = bits;
        tick();
        if (rr) r_req = '0; else f_req = '0;
    endtask

    task automatic do_ack(input bit rr);
        if (rr) r_ack = 1'b1; else f_ack = 1'b1;
        tick();
        if (rr) r_ack = 1'b0; else f_ack = 1'b0;
    endtask

    task automatic write_mask(input bit rr, input logic [N-1:0] m);
        if (rr) begin r_mask_in = m; r_mask_wr = 1'b1; end
        else    begin f_mask_in = m; f_mask_wr = 1'b1; end
        tick();
        r_mask_wr = 1'b0;
        f_mask_wr = 1'b0;
    endtask

    task automatic wait_irq(input bit rr, input string name);
        int n = 0;
        while (!(rr ? r_irq : f_irq) && n < 20) begin
            tick();
            n++;
        end
        check(name, 32'(rr ? r_irq : f_irq), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        rst_n = 1'b0;
        repeat (2) tick();
        check("rst_irq",  32'(f_irq),  32'd0);
        check("rst_id",   32'(f_id),   32'd0);
        check("rst_pend", 32'(f_pend), 32'd0);
        check("rst_mask", 32'(f_mask), 32'd0);
        check("rst_rr_irq", 32'(r_irq), 32'd0);
        rst_n = 1'b1;
        tick();

        // Fixed mode, simultaneous rises on 5 and 2
        exp_f.push_back(5);
        exp_f.push_back(2);
        pulse(0, 8'b0010_0100);
        check("simul_pend", 32'(f_pend), 32'h24);
        check("simul_irq_lat1", 32'(f_irq), 32'd0);
        tick();
        check("simul_irq_lat2", 32'(f_irq), 32'd1);
        do_ack(0);
        check("simul_ack_irq", 32'(f_irq), 32'd0);
        check("simul_ack_pend", 32'(f_pend), 32'h04);
        tick();
        check("simul_second_irq", 32'(f_irq), 32'd1);
        do_ack(0);
        repeat (3) tick();
        check("simul_idle_irq", 32'(f_irq), 32'd0);
        check("simul_idle_pend", 32'(f_pend), 32'd0);

        // Masking keeps the pending bit
        write_mask(0, 8'h80);
        check("mask_reg", 32'(f_mask), 32'h80);
        exp_f.push_back(0);
        pulse(0, 8'h81);
        wait_irq(0, "mask_irq0");
        check("mask_pend_both", 32'(f_pend), 32'h81);
        do_ack(0);
        repeat (2) tick();
        check("mask_blocked_irq", 32'(f_irq), 32'd0);
        check("mask_pend_kept", 32'(f_pend), 32'h80);
        exp_f.push_back(7);
        write_mask(0, 8'h00);
        wait_irq(0, "unmask_irq7");
        check("unmask_pend", 32'(f_pend), 32'h80);
        do_ack(0);
        tick();
        check("unmask_pend_clr", 32'(f_pend), 32'd0);

        // Set/clear collision on bit 4
        exp_f.push_back(4);
        exp_f.push_back(4);
        pulse(0, 8'h10);
        wait_irq(0, "coll_irq");
        f_ack = 1'b1;
        f_req = 8'h10;
        tick();
        f_ack = 1'b0;
        f_req = '0;
        check("coll_pend", 32'(f_pend), 32'h10);
        check("coll_irq_low", 32'(f_irq), 32'd0);
        tick();
        check("coll_regrant", 32'(f_irq), 32'd1);
        do_ack(0);
        tick();

        // Grant stability under new rise and masking of the granted source
        exp_f.push_back(2);
        pulse(0, 8'h04);
        wait_irq(0, "stab_irq");
        f_req = 8'h40;
        f_mask_in = 8'h04;
        f_mask_wr = 1'b1;
        tick();
        f_req = '0;
        f_mask_wr = 1'b0;
        repeat (2) tick();
        check("stab_irq_held", 32'(f_irq), 32'd1);
        check("stab_id_held", 32'(f_id), 32'd2);
        check("stab_pend", 32'(f_pend), 32'h44);
        check("stab_mask", 32'(f_mask), 32'h04);
        exp_f.push_back(6);
        do_ack(0);
        wait_irq(0, "stab_next_irq");
        do_ack(0);
        repeat (2) tick();
        check("stray_pre_irq", 32'(f_irq), 32'd0);
        check("stray_pre_id", 32'(f_id), 32'd6);
        f_ack = 1'b1;
        tick();
        f_ack = 1'b0;
        tick();
        check("stray_irq", 32'(f_irq), 32'd0);
        check("stray_pend", 32'(f_pend), 32'd0);
        check("stray_id", 32'(f_id), 32'd6);
        check("stray_mask", 32'(f_mask), 32'h04);
        write_mask(0, 8'h00);

        // Reset mid-grant with req[0] held high
        exp_f.push_back(0);
        exp_f.push_back(0);
        f_req = 8'h01;
        tick();
        wait_irq(0, "rstmid_irq");
        rst_n = 1'b0;
        tick();
        check("rstmid_irq", 32'(f_irq), 32'd0);
        check("rstmid_pend", 32'(f_pend), 32'd0);
        check("rstmid_id", 32'(f_id), 32'd0);
        rst_n = 1'b1;
        tick();
        check("rstrel_pend", 32'(f_pend), 32'h01);
        check("rstrel_irq0", 32'(f_irq), 32'd0);
        tick();
        check("rstrel_irq1", 32'(f_irq), 32'd1);
        check("rstrel_id", 32'(f_id), 32'd0);
        do_ack(0);
        f_req = '0;
        tick();

        // Round-robin rotation: 7 first, then 3 and 1 joined, re-pulsing 7 and 3
        exp_r.push_back(7);
        exp_r.push_back(3);
        exp_r.push_back(1);
        exp_r.push_back(7);
        exp_r.push_back(3);
        pulse(1, 8'h80);
        wait_irq(1, "rr_irq_a");
        pulse(1, 8'h0A);
        check("rr_pend_a", 32'(r_pend), 32'h8A);
        do_ack(1);
        pulse(1, 8'h80);
        wait_irq(1, "rr_irq_b");
        do_ack(1);
        pulse(1, 8'h08);
        wait_irq(1, "rr_irq_c");
        do_ack(1);
        wait_irq(1, "rr_irq_d");
        do_ack(1);
        wait_irq(1, "rr_irq_e");
        do_ack(1);
        repeat (3) tick();
        check("rr_idle_irq", 32'(r_irq), 32'd0);
        check("rr_idle_pend", 32'(r_pend), 32'd0);

        repeat (5) tick();
        check("fix_queue_drained", 32'(exp_f.size()), 32'd0);
        check("rr_queue_drained", 32'(exp_r.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/priority_irq_ctrl.md
# priority_irq_ctrl

Parametrised, registered N-input priority interrupt controller: the sequential successor to the team's combinational 8-to-3 priority encoder. Edge-detects request lines into pending latches, applies a writable mask, selects one pending source by fixed or round-robin priority, and presents a stable `irq`/`id` pair until acknowledged. It sits between peripheral request lines and a single service agent (CPU stub or sequencer) in the RTL test designs.

## Interface
- `N`, 8: number of request inputs; legal range 2..32.
- `W`, `$clog2(N)`: width of `id`; derived, never overridden.
- `MODE`, 0: priority mode. 0 = fixed, where the highest index wins, as in the 8-to-3 encoder. 1 = round-robin.

- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: synchronous, active-low reset.
- `req`  in  N: level request lines. Synchronous to `clk`. A 0→1 transition marks a new event.
- `mask_wr`  in  1: when high, load `mask_in` into the mask register.
- `mask_in`  in  N: new mask value. Bit = 1 blocks that source.
- `ack`  in  1: service agent acknowledges the current `id`.
- `irq`  out  1: a source is granted; `id` is valid.
- `id`  out  W: index of the granted source. Stable while `irq` = 1.
- `pend`  out  N: pending latch contents, registered.
- `mask`  out  N: current mask register.

## Operation
- **Edge detect.** `req_q` <= `req`. Rise = `req & ~req_q`.
- **Pending update.** `pend` <= (`pend` & ~clr) | rise.
  - Set wins over clear on the same bit in the same cycle.
  - A rise on an already-pending bit is absorbed. There is no counting.
- **Candidates.** `pend & ~mask`.
  - Masking never clears `pend`.
  - Unmasking a pending bit makes it eligible on the next evaluation.
- **Fixed mode.** The highest set candidate index is selected.
- **Round-robin mode.** A pointer `last` (W bits) holds the most recently serviced id.
  - Search order is `last-1`, `last-2`, …, wrapping from 0 to N-1, ending at `last`.
  - This makes the just-serviced source the lowest priority.
  - `last` updates only on an accepted ack.
- **FSM.** Two states, `IDLE` and `GRANT`.
  - `IDLE`: if any candidate exists, register the selected index into `id`, set `irq` = 1, go to `GRANT`. Otherwise stay, with `irq` = 0.
  - `GRANT`: hold `id` and `irq` unchanged regardless of `req`, `mask` or new pending bits.
    - Masking the granted source during `GRANT` does not revoke the grant.
    - On `ack` = 1: clr = one-hot(`id`), `irq` <= 0, `last` <= `id` (round-robin mode), go to `IDLE`.
- **Stray ack.** `ack` while `irq` = 0 is ignored.
- **Mask write.** `mask_wr` takes effect at the next edge in either state. The new mask is used by the next `IDLE` evaluation.
- **Reset values.** `irq` = 0, `id` = 0, `pend` = 0, `mask` = 0 (all enabled), `req_q` = 0, `last` = N-1, state = `IDLE`.
  - Reset asserted mid-grant drops the grant and all pending events with no ack.
  - A `req` held high through reset registers as a rise on the first edge after release.

## Timing
- A `req` rise sampled at edge t shows in `pend` after edge t.
- With the controller idle and the source unmasked, `irq`/`id` are visible after edge t+1. Latency is 2 cycles from request to `irq`.
- `ack` sampled at edge k: `irq` = 0 and `pend[id]` is cleared after edge k. The cleared bit is re-set if a rise occurs at k.
- `irq` is low for at least one full cycle between grants. The earliest next grant is visible after edge k+1.
- The mask register updates one cycle after `mask_wr`.
- Sustained throughput is one grant per 2 cycles when `ack` is returned immediately.

## Structure
- Shared package `pri_enc_pkg`:
  - mode constants `MODE_FIXED` = 0 and `MODE_RR` = 1;
  - FSM state type (`IDLE`, `GRANT`).
- Sub-module `pri_rotate_enc`: combinational N-to-W encoder.
  - Inputs: candidate vector and rotate amount. Outputs: index and `any`.
  - Rotate by `last` in round-robin mode; tie the rotate amount to 0 in fixed mode.
  - `priority_irq_ctrl` holds all registers and the FSM.

## Test plan
- **Fixed mode, simultaneous rises.** N=8, MODE=0, rise `req` = 8'b0010_0100 in one cycle → `irq` after 2 cycles with `id` = 5. After ack, `id` = 2 is granted, then `irq` stays 0.
- **Round-robin rotation.** MODE=1, `req` held rising on bits 7, 3 and 1 → grants in order 7, 3, 1, 7. Re-pulse each source after its ack.
- **Masking.** Set `mask` = 8'h80, then rise bits 7 and 0 → `id` = 0 granted. Unmask → `id` = 7 granted next, with `pend[7]` retained throughout.
- **Set/clear collision.** Bit 4 re-rises in the same cycle as the ack of `id` = 4 → `pend[4]` stays 1 and `id` = 4 is granted again 2 cycles later.
- **Grant stability and stray ack.** During `GRANT` of `id` = 2, rise bit 6 and mask bit 2 → `id` stays 2 until ack. A stray ack while `irq` = 0 leaves all state unchanged.
- **Reset mid-grant.** Drive `rst_n` = 0 for 1 cycle while `irq` = 1 with `req` = 8'h01 held high → `irq`, `pend`, `id` = 0 after reset. `pend[0]` = 1 one cycle after release, and `irq` with `id` = 0 follows one cycle later.
